// File: rtl/lms_coeff_update_pkg.sv
// Shared types and helpers for the LMS coefficient updater.
package lms_coeff_update_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        COMMIT = 2'd2
    } lms_state_t;

    // Wide enough for any accumulator + delta combination used by the updater.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic             clipped;
        logic [SAT_W-1:0] value;
    } sat_res_t;

    // Error width: exact difference of two DIN_WIDTH signed values.
    function automatic int e_width(input int din_width);
        return din_width + 1;
    endfunction

    // Product width: error times sample, exact.
    function automatic int p_width(input int din_width);
        return 2 * din_width + 1;
    endfunction

    // Signed add, then clip to a signed range of the given width.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                         input logic signed [SAT_W-1:0] delta,
                                         input int                      width);
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_res_t                res;
        sum   = acc + delta;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (sum > max_v) begin
            res.clipped = 1'b1;
            res.value   = max_v;
        end else if (sum < min_v) begin
            res.clipped = 1'b1;
            res.value   = min_v;
        end else begin
            res.clipped = 1'b0;
            res.value   = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/lms_coeff_update_if.sv
// Sample stream into the updater: din/desired/y aligned, with valid/ready.
interface lms_coeff_update_if #(
    parameter int DIN_WIDTH = 16
) ();
    logic                        sample_valid;
    logic                        sample_ready;
    logic signed [DIN_WIDTH-1:0] din;
    logic signed [DIN_WIDTH-1:0] desired;
    logic signed [DIN_WIDTH-1:0] y;
    logic                        adapt_en;

    modport master (
        output sample_valid, din, desired, y, adapt_en,
        input  sample_ready
    );

    modport slave (
        input  sample_valid, din, desired, y, adapt_en,
        output sample_ready
    );
endinterface

// File: rtl/lms_coeff_update_mac.sv
// One-tap LMS step: w + ((e * x) >>> MU_SHIFT), clipped to the coefficient range.
module lms_tap_mac
    import lms_coeff_update_pkg::*;
#(
    parameter int DIN_WIDTH  = 16,
    parameter int COEF_WIDTH = 16,
    parameter int MU_SHIFT   = 8
) (
    input  logic signed [DIN_WIDTH:0]    e,
    input  logic signed [DIN_WIDTH-1:0]  x,
    input  logic signed [COEF_WIDTH-1:0] w,
    output logic signed [COEF_WIDTH-1:0] w_next,
    output logic                         clipped
);

    localparam int E_W = e_width(DIN_WIDTH);
    localparam int P_W = p_width(DIN_WIDTH);

    logic signed [P_W-1:0]   e_ext;
    logic signed [P_W-1:0]   x_ext;
    logic signed [P_W-1:0]   p;
    logic signed [P_W-1:0]   d;
    logic signed [SAT_W-1:0] acc;
    logic signed [SAT_W-1:0] delta;
    sat_res_t                res;
    logic                    unused_hi;

    assign e_ext = {{(P_W - E_W){e[E_W-1]}}, e};
    assign x_ext = {{(P_W - DIN_WIDTH){x[DIN_WIDTH-1]}}, x};
    // |e| < 2^DIN_WIDTH and |x| <= 2^(DIN_WIDTH-1), so the product never overflows P_W.
    assign p     = e_ext * x_ext;
    // Arithmetic shift floors toward minus infinity, which is the intended step rounding.
    assign d     = p >>> MU_SHIFT;
    assign acc   = {{(SAT_W - COEF_WIDTH){w[COEF_WIDTH-1]}}, w};
    assign delta = {{(SAT_W - P_W){d[P_W-1]}}, d};

    // Saturating accumulate of the weight step.
    always_comb begin
        res = sat_add(acc, delta, COEF_WIDTH);
    end

    assign w_next    = res.value[COEF_WIDTH-1:0];
    assign clipped   = res.clipped;
    // After clipping the upper bits are pure sign copies.
    assign unused_hi = ^res.value[SAT_W-1:COEF_WIDTH];

endmodule

// File: rtl/lms_coeff_update.sv
// LMS weight adaptation beside a transposed FIR: serial per-tap update into a
// working bank, then an atomic commit to the coefficient bus.
module lms_coeff_update
    import lms_coeff_update_pkg::*;
#(
    parameter int DIN_WIDTH  = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 16,
    parameter int MU_SHIFT   = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    lms_coeff_update_if.slave            smp,
    input  logic                         coeff_clear,
    output logic [TAPS*COEF_WIDTH-1:0]   coeffs,
    output logic signed [DIN_WIDTH:0]    err_out,
    output logic                         update_done,
    output logic                         overrun,
    output logic                         sat_flag
);

    localparam int E_W   = e_width(DIN_WIDTH);
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    lms_state_t               state_reg;
    lms_state_t               state_next;
    logic [IDX_W-1:0]         idx_reg;
    logic [IDX_W-1:0]         idx_next;

    logic                     accept;
    logic                     tap_we;
    logic                     commit;
    logic                     drop;

    logic signed [E_W-1:0]        e_new;
    logic signed [E_W-1:0]        e_reg;
    logic signed [DIN_WIDTH-1:0]  x_reg     [TAPS];
    logic signed [COEF_WIDTH-1:0] work_reg  [TAPS];
    logic signed [COEF_WIDTH-1:0] coeff_reg [TAPS];

    logic signed [DIN_WIDTH-1:0]  x_sel;
    logic signed [COEF_WIDTH-1:0] w_sel;
    logic signed [COEF_WIDTH-1:0] mac_w_next;
    logic                         mac_clip;

    // Exact error in one extra bit so desired - y can never wrap.
    assign e_new = {smp.desired[DIN_WIDTH-1], smp.desired} - {smp.y[DIN_WIDTH-1], smp.y};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state logic and per-cycle control strobes; clear overrides every transition.
    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        accept           = 1'b0;
        tap_we           = 1'b0;
        commit           = 1'b0;
        drop             = 1'b0;
        smp.sample_ready = (state_reg == IDLE);
        if (coeff_clear) begin
            state_next = IDLE;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (smp.sample_valid) begin
                        accept = 1'b1;
                        if (smp.adapt_en) begin
                            state_next = UPDATE;
                            idx_next   = '0;
                        end
                    end
                end
                UPDATE: begin
                    tap_we = 1'b1;
                    if (idx_reg == IDX_W'(TAPS - 1)) begin
                        state_next = COMMIT;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
                COMMIT: begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
            drop = smp.sample_valid && (state_reg != IDLE);
        end
    end

    // Latch the error of each accepted sample for the update and for observation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_reg   <= '0;
            err_out <= '0;
        end else if (coeff_clear) begin
            e_reg   <= '0;
            err_out <= '0;
        end else if (accept) begin
            e_reg   <= e_new;
            err_out <= e_new;
        end
    end

    // The single MAC is time-shared across taps by the idx mux.
    assign x_sel = x_reg[idx_reg];
    assign w_sel = work_reg[idx_reg];

    lms_tap_mac #(
        .DIN_WIDTH  (DIN_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .MU_SHIFT   (MU_SHIFT)
    ) u_mac (
        .e       (e_reg),
        .x       (x_sel),
        .w       (w_sel),
        .w_next  (mac_w_next),
        .clipped (mac_clip)
    );

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                // Newest sample enters the history on accept.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        x_reg[gi] <= '0;
                    end else if (coeff_clear) begin
                        x_reg[gi] <= '0;
                    end else if (accept) begin
                        x_reg[gi] <= smp.din;
                    end
                end
            end else begin : g_body
                // History shifts one place on accept; dropped samples leave it alone.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        x_reg[gi] <= '0;
                    end else if (coeff_clear) begin
                        x_reg[gi] <= '0;
                    end else if (accept) begin
                        x_reg[gi] <= x_reg[gi-1];
                    end
                end
            end

            // Working bank: written one tap per cycle while updating.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    work_reg[gi] <= '0;
                end else if (coeff_clear) begin
                    work_reg[gi] <= '0;
                end else if (tap_we && (idx_reg == IDX_W'(gi))) begin
                    work_reg[gi] <= mac_w_next;
                end
            end

            // Committed bank: copied whole so the FIR never sees a partial set.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    coeff_reg[gi] <= '0;
                end else if (coeff_clear) begin
                    coeff_reg[gi] <= '0;
                end else if (commit) begin
                    coeff_reg[gi] <= work_reg[gi];
                end
            end

            assign coeffs[gi*COEF_WIDTH +: COEF_WIDTH] = coeff_reg[gi];
        end
    endgenerate

    // Status pulses and the sticky saturation flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            update_done <= 1'b0;
            overrun     <= 1'b0;
            sat_flag    <= 1'b0;
        end else if (coeff_clear) begin
            update_done <= 1'b0;
            overrun     <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            update_done <= commit;
            overrun     <= drop;
            if (tap_we && mac_clip) begin
                sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lms_coeff_update.sv
// Self-checking bench for lms_coeff_update against an arithmetic LMS model.
module tb_lms_coeff_update;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 4;
    localparam int MU   = 0;
    localparam longint WMAX = 32767;
    localparam longint WMIN = -32768;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  coeff_clear = 1'b0;
    logic [TAPS*CW-1:0]    coeffs;
    logic signed [DW:0]    err_out;
    logic                  update_done;
    logic                  overrun;
    logic                  sat_flag;

    int checks   = 0;
    int failures = 0;

    longint w_m [TAPS];
    longint x_m [TAPS];
    longint e_m;
    bit     sat_m;
    bit     early;

    lms_coeff_update_if #(.DIN_WIDTH(DW)) smp ();

    lms_coeff_update #(
        .DIN_WIDTH  (DW),
        .COEF_WIDTH (CW),
        .TAPS       (TAPS),
        .MU_SHIFT   (MU)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .smp         (smp),
        .coeff_clear (coeff_clear),
        .coeffs      (coeffs),
        .err_out     (err_out),
        .update_done (update_done),
        .overrun     (overrun),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [TAPS*CW-1:0] pack_m();
        logic [TAPS*CW-1:0] v;
        longint             t;
        v = '0;
        for (int k = 0; k < TAPS; k++) begin
            t = w_m[k];
            v[k*CW +: CW] = t[CW-1:0];
        end
        return v;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < TAPS; k++) begin
            w_m[k] = 0;
            x_m[k] = 0;
        end
        e_m   = 0;
        sat_m = 1'b0;
    endfunction

    function automatic void model_accept(input longint d, input longint des, input longint yv);
        for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
        x_m[0] = d;
        e_m    = des - yv;
    endfunction

    function automatic void model_update();
        longint s;
        for (int k = 0; k < TAPS; k++) begin
            s = w_m[k] + ((e_m * x_m[k]) >>> MU);
            if (s > WMAX) begin
                s = WMAX;
                sat_m = 1'b1;
            end else if (s < WMIN) begin
                s = WMIN;
                sat_m = 1'b1;
            end
            w_m[k] = s;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int d, input int des, input int yv, input bit adapt, input bit valid);
        smp.din          = d[DW-1:0];
        smp.desired      = des[DW-1:0];
        smp.y            = yv[DW-1:0];
        smp.adapt_en     = adapt;
        smp.sample_valid = valid;
    endtask

    task automatic wait_done(output int n);
        n     = 0;
        early = 1'b0;
        while (update_done !== 1'b1 && n < TAPS + 8) begin
            if (coeffs !== pack_m()) early = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_update(input int n, input int exp_n, input string tag);
        chk({tag, "_latency"}, 64'(n), 64'(exp_n));
        chk({tag, "_early_change"}, 64'(early), 64'd0);
        model_update();
        chk({tag, "_coeffs"}, 64'(coeffs), 64'(pack_m()));
        chk({tag, "_sat"}, 64'(sat_flag), 64'(sat_m));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(update_done), 64'd0);
    endtask

    // Called at a negedge with the DUT idle.
    task automatic do_sample(input int d, input int des, input int yv, input bit adapt, input string tag);
        int n;
        chk({tag, "_ready"}, 64'(smp.sample_ready), 64'd1);
        drive(d, des, yv, adapt, 1'b1);
        @(negedge clk);
        smp.sample_valid = 1'b0;
        model_accept(d, des, yv);
        chk({tag, "_err"}, 64'(err_out), 64'(e_m));
        if (adapt) begin
            wait_done(n);
            finish_update(n, TAPS + 1, tag);
        end else begin
            chk({tag, "_nodone"}, 64'(update_done), 64'd0);
            chk({tag, "_coeffs_hold"}, 64'(coeffs), 64'(pack_m()));
        end
        $display("txn %s din=%0d desired=%0d y=%0d adapt=%0d e=%0d coeffs=%h sat=%0d",
                 tag, d, des, yv, adapt, e_m, coeffs, sat_flag);
    endtask

    task automatic clear_pulse(input string tag);
        coeff_clear = 1'b1;
        @(negedge clk);
        coeff_clear = 1'b0;
        model_clear();
        chk({tag, "_coeffs"}, 64'(coeffs), 64'd0);
        chk({tag, "_sat"}, 64'(sat_flag), 64'd0);
        chk({tag, "_err"}, 64'(err_out), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  n;
        bit  saw_done;

        drive(0, 0, 0, 1'b0, 1'b0);
        model_clear();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("rst_coeffs", 64'(coeffs), 64'd0);
        chk("rst_err", 64'(err_out), 64'd0);
        chk("rst_ready", 64'(smp.sample_ready), 64'd1);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        chk("rst_done", 64'(update_done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // Basic update from zero history.
        do_sample(2, 10, 4, 1'b1, "basic");
        chk("basic_err_const", 64'(err_out), 64'd6);
        chk("basic_coeffs_const", 64'(coeffs), 64'd12);

        // Saturation both ways.
        clear_pulse("clr_idle");
        do_sample(32767, 32767, -32768, 1'b1, "sat1");
        chk("sat1_err_const", 64'(err_out), 64'd65535);
        chk("sat1_w0", 64'(coeffs[CW-1:0]), 64'h7fff);
        chk("sat1_flag", 64'(sat_flag), 64'd1);
        do_sample(-32768, 32767, -32768, 1'b1, "sat2");
        chk("sat2_w0", 64'(coeffs[CW-1:0]), 64'h8000);
        chk("sat2_flag_held", 64'(sat_flag), 64'd1);

        // Asynchronous reset in the middle of an update.
        drive(5, 9, 1, 1'b1, 1'b1);
        @(negedge clk);
        smp.sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        model_clear();
        chk("midrst_coeffs", 64'(coeffs), 64'd0);
        chk("midrst_err", 64'(err_out), 64'd0);
        chk("midrst_ready", 64'(smp.sample_ready), 64'd1);
        chk("midrst_sat", 64'(sat_flag), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        saw_done = 1'b0;
        repeat (TAPS + 3) begin
            @(negedge clk);
            if (update_done) saw_done = 1'b1;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);
        $display("txn midrst coeffs=%h", coeffs);

        // Overrun: a second sample while busy is dropped.
        drive(100, 50, 0, 1'b1, 1'b1);
        @(negedge clk);
        smp.sample_valid = 1'b0;
        model_accept(100, 50, 0);
        drive(7777, 1000, 0, 1'b1, 1'b1);
        @(negedge clk);
        smp.sample_valid = 1'b0;
        chk("ovr_pulse", 64'(overrun), 64'd1);
        chk("ovr_err_kept", 64'(err_out), 64'(e_m));
        @(negedge clk);
        chk("ovr_pulse_end", 64'(overrun), 64'd0);
        wait_done(n);
        finish_update(n, TAPS + 1 - 2, "ovr");
        $display("txn overrun coeffs=%h", coeffs);
        do_sample(-3, 7, 2, 1'b1, "ovr_next");

        // Track-only samples, then an adapt that uses all of them.
        do_sample(11, 20, 5, 1'b0, "track0");
        do_sample(-6, -4, 9, 1'b0, "track1");
        do_sample(3, 0, -8, 1'b0, "track2");
        do_sample(1, 2, 1, 1'b1, "track_adapt");

        // Clear together with a sample during COMMIT.
        drive(3, 20, 0, 1'b1, 1'b1);
        @(negedge clk);
        smp.sample_valid = 1'b0;
        model_accept(3, 20, 0);
        repeat (4) @(negedge clk);
        coeff_clear = 1'b1;
        drive(999, 40, 0, 1'b1, 1'b1);
        @(negedge clk);
        coeff_clear      = 1'b0;
        smp.sample_valid = 1'b0;
        model_clear();
        chk("clrc_done", 64'(update_done), 64'd0);
        chk("clrc_coeffs", 64'(coeffs), 64'd0);
        chk("clrc_ready", 64'(smp.sample_ready), 64'd1);
        chk("clrc_err", 64'(err_out), 64'd0);
        chk("clrc_sat", 64'(sat_flag), 64'd0);
        @(negedge clk);
        chk("clrc_no_done", 64'(update_done), 64'd0);
        $display("txn clear_commit coeffs=%h", coeffs);
        do_sample(4, 8, 1, 1'b1, "post_clear");

        // Randomised samples, small and full-range.
        for (int i = 0; i < 24; i++) begin
            int                 a;
            int                 b;
            int                 c;
            bit                 ad;
            logic signed [15:0] r;
            if ($urandom_range(0, 1) == 1) begin
                a = int'($urandom_range(0, 30)) - 15;
                b = int'($urandom_range(0, 30)) - 15;
                c = int'($urandom_range(0, 30)) - 15;
            end else begin
                r = 16'($urandom); a = int'(r);
                r = 16'($urandom); b = int'(r);
                r = 16'($urandom); c = int'(r);
            end
            ad = ($urandom_range(0, 3) != 0);
            do_sample(a, b, c, ad, "rnd");
            if ($urandom_range(0, 7) == 0) clear_pulse("rnd_clr");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
